// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// ALU timeout detection, sticky HALT/ERROR and a saturating retire counter.
module instr_sequencer #(
    parameter int ALU_TIMEOUT = 32,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             imem_valid,
    input  logic             alu_done,
    input  logic             dm_ack,
    output logic             ir_we,
    output logic             alu_start,
    output logic             dm_req,
    output logic             dm_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam int CW = (ALU_TIMEOUT < 2) ? 1 : $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(ALU_TIMEOUT - 1);

    state_t          state_p0, state_nx;
    logic [5:0]      op_p0;
    logic [CW-1:0]   wait_p0;
    logic            first_p0;
    logic [RET_W-1:0] ret_p0;

    function automatic logic is_multi(input logic [5:0] op);
        return (op == 6'd3) || (op == 6'd4) || (op == 6'd20) || (op == 6'd21);
    endfunction

    function automatic logic writes_rf(input logic [5:0] op);
        return ((op >= 6'd1) && (op <= 6'd24)) || (op == 6'd26);
    endfunction

    // Registered control state; the wait counter restarts on every EXEC entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= S_FETCH;
            op_p0    <= '0;
            wait_p0  <= '0;
            first_p0 <= 1'b0;
            ret_p0   <= '0;
        end else begin
            state_p0 <= state_nx;
            first_p0 <= (state_p0 == S_DECODE);
            if (state_p0 == S_FETCH && imem_valid)
                op_p0 <= opcode;
            if (state_p0 == S_EXEC)
                wait_p0 <= wait_p0 + CW'(1);
            else
                wait_p0 <= '0;
            if (state_p0 == S_WB && ret_p0 != '1)
                ret_p0 <= ret_p0 + RET_W'(1);
        end
    end

    always_comb begin
        state_nx = state_p0;
        case (state_p0)
            S_FETCH:  if (imem_valid) state_nx = S_DECODE;
            S_DECODE: begin
                if (op_p0 == 6'd0)       state_nx = S_HALT;
                else if (op_p0 <= 6'd23) state_nx = S_EXEC;
                else if (op_p0 <= 6'd27) state_nx = S_MEM;
                else if (op_p0 <= 6'd31) state_nx = S_WB;
                else                     state_nx = S_ERROR;
            end
            S_EXEC: begin
                // alu_done on the expiry cycle still completes the instruction
                if (!is_multi(op_p0) || alu_done) state_nx = S_WB;
                else if (wait_p0 == WAIT_LAST)    state_nx = S_ERROR;
            end
            S_MEM:    if (dm_ack) state_nx = S_WB;
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            S_ERROR:  state_nx = S_ERROR;
            default:  state_nx = S_FETCH;
        endcase
    end

    // ir_we follows imem_valid so a ready word is loaded in its first FETCH cycle
    always_comb begin
        ir_we     = 1'b0;
        alu_start = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        case (state_p0)
            S_FETCH: ir_we     = imem_valid & ~rst;
            S_EXEC:  alu_start = first_p0 & is_multi(op_p0);
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = (op_p0 == 6'd25) || (op_p0 == 6'd27);
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = writes_rf(op_p0);
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err    = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_p0;
    assign retired = ret_p0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: per-instruction plans expand into
// expected output traces that one compare process checks every cycle.
module tb_instr_sequencer;

    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0;
    logic        imem_valid = 1'b0, alu_done = 1'b0, dm_ack = 1'b0;

    logic        ir_we, alu_start, dm_req, dm_we, rf_we, pc_we, halted, err;
    logic [2:0]  st;
    logic [15:0] ret16;
    logic        ir_we2, alu_start2, dm_req2, dm_we2, rf_we2, pc_we2, halted2, err2;
    logic [2:0]  st2;
    logic [1:0]  ret2;

    instr_sequencer #(.ALU_TIMEOUT(T), .RET_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_valid(imem_valid),
        .alu_done(alu_done), .dm_ack(dm_ack), .ir_we(ir_we), .alu_start(alu_start),
        .dm_req(dm_req), .dm_we(dm_we), .rf_we(rf_we), .pc_we(pc_we),
        .halted(halted), .err(err), .state(st), .retired(ret16)
    );

    instr_sequencer #(.ALU_TIMEOUT(T), .RET_W(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_valid(imem_valid),
        .alu_done(alu_done), .dm_ack(dm_ack), .ir_we(ir_we2), .alu_start(alu_start2),
        .dm_req(dm_req2), .dm_we(dm_we2), .rf_we(rf_we2), .pc_we(pc_we2),
        .halted(halted2), .err(err2), .state(st2), .retired(ret2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir, as_, rq, we, rf, pc, h, er;
        logic [15:0] r16;
        logic [1:0]  r2;
    } exp_t;

    exp_t expq[$];
    int   checks = 0, failures = 0;
    int   m_ret = 0;
    logic iv_hi = 1'b0;

    int n_as = 0, n_exec = 0, n_req = 0, n_we = 0, n_pc = 0, n_rf = 0, n_ir = 0;
    int cycn = 0, last_ir = 0, ir_gap = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] s, input logic ir, input logic as_,
                                input logic rq, input logic we, input logic rf, input logic pc);
        exp_t e;
        e.st = s; e.ir = ir; e.as_ = as_; e.rq = rq; e.we = we; e.rf = rf; e.pc = pc;
        e.h = (s == 3'd5);
        e.er = (s == 3'd6);
        e.r16 = (m_ret > 65535) ? 16'hFFFF : 16'(m_ret);
        e.r2 = (m_ret > 3) ? 2'd3 : 2'(m_ret);
        return e;
    endfunction

    function automatic logic nz();
        return 1'($urandom % 2);
    endfunction

    function automatic logic ivn();
        return iv_hi ? 1'b1 : nz();
    endfunction

    // Compare process and activity monitor, both away from the active edge
    always @(negedge clk) begin
        exp_t e;
        cycn++;
        n_as += int'(alu_start); n_exec += int'(st == 3'd2); n_req += int'(dm_req);
        n_we += int'(dm_we); n_pc += int'(pc_we); n_rf += int'(rf_we); n_ir += int'(ir_we);
        if (ir_we) begin
            ir_gap = cycn - last_ir;
            last_ir = cycn;
        end
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("cycle", {3'b0, st, ir_we, alu_start, dm_req, dm_we, rf_we, pc_we, halted, err, ret16, ret2},
                {3'b0, e});
        end
    end

    task automatic cyc(input logic iv, input logic [5:0] op, input logic ad, input logic ack, input exp_t e);
        @(posedge clk);
        #1;
        imem_valid = iv; opcode = op; alu_done = ad; dm_ack = ack;
        expq.push_back(e);
    endtask

    task automatic after();
        #5;
    endtask

    task automatic idle();
        cyc(1'b0, 6'($urandom), nz(), nz(), mk(3'd0, 0, 0, 0, 0, 0, 0));
        after();
    endtask

    // Expands one instruction plan (gap, ALU delay d, memory delay k) into a trace
    task automatic do_instr(input logic [5:0] op, input int gap, input int d, input int k);
        logic mc;
        mc = (op == 6'd3) || (op == 6'd4) || (op == 6'd20) || (op == 6'd21);
        for (int i = 0; i < gap; i++)
            cyc(1'b0, 6'($urandom), nz(), nz(), mk(3'd0, 0, 0, 0, 0, 0, 0));
        cyc(1'b1, op, nz(), nz(), mk(3'd0, 1, 0, 0, 0, 0, 0));
        cyc(ivn(), 6'($urandom), nz(), nz(), mk(3'd1, 0, 0, 0, 0, 0, 0));
        if (op == 6'd0 || op >= 6'd32) return;
        if (op <= 6'd23) begin
            if (mc) begin
                if (d >= T) begin
                    for (int i = 0; i < T; i++)
                        cyc(ivn(), 6'($urandom), 1'b0, nz(), mk(3'd2, 0, i == 0, 0, 0, 0, 0));
                    return;
                end
                for (int i = 0; i <= d; i++)
                    cyc(ivn(), 6'($urandom), i == d, nz(), mk(3'd2, 0, i == 0, 0, 0, 0, 0));
            end else begin
                cyc(ivn(), 6'($urandom), nz(), nz(), mk(3'd2, 0, 0, 0, 0, 0, 0));
            end
        end else if (op <= 6'd27) begin
            for (int i = 1; i <= k; i++)
                cyc(ivn(), 6'($urandom), nz(), i == k,
                    mk(3'd3, 0, 0, 1, (op == 6'd25) || (op == 6'd27), 0, 0));
        end
        cyc(ivn(), 6'($urandom), nz(), nz(),
            mk(3'd4, 0, 0, 0, 0, (op <= 6'd24) || (op == 6'd26), 1));
        m_ret++;
    endtask

    task automatic do_dead(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++)
            cyc(ivn(), 6'($urandom), nz(), nz(), mk(s, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_retired", 32'(ret16), 32'd0);
        chk("rst_err_halt", {30'd0, err, halted}, 32'd0);
        m_ret = 0;
        cyc(1'b0, 6'd0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_as, s_exec, s_req, s_we, s_pc, s_rf, s_ir;
        do_reset();

        // single-cycle ALU op with imem_valid held high
        iv_hi = 1'b1;
        do_instr(6'd1, 0, 0, 0);
        do_instr(6'd1, 0, 0, 0);
        chk("alu_latency", 32'(ir_gap), 32'd4);
        idle();
        chk("retired_two", 32'(ret16), 32'd2);

        // multi-cycle op 4, alu_done five cycles after alu_start
        s_as = n_as; s_exec = n_exec; s_rf = n_rf;
        do_instr(6'd4, 0, 5, 0);
        after();
        chk("mc_alu_start", 32'(n_as - s_as), 32'd1);
        chk("mc_exec_cycles", 32'(n_exec - s_exec), 32'd6);
        chk("mc_rf_we", 32'(n_rf - s_rf), 32'd1);

        // store 27 with dm_ack after three cycles, then branch 30, then halt
        s_req = n_req; s_we = n_we; s_rf = n_rf; s_pc = n_pc;
        do_instr(6'd27, 0, 0, 3);
        after();
        chk("st_dm_req", 32'(n_req - s_req), 32'd3);
        chk("st_dm_we", 32'(n_we - s_we), 32'd3);
        chk("st_rf_we", 32'(n_rf - s_rf), 32'd0);
        chk("st_pc_we", 32'(n_pc - s_pc), 32'd1);
        s_rf = n_rf; s_pc = n_pc;
        do_instr(6'd30, 0, 0, 0);
        after();
        chk("mem_latency", 32'(ir_gap), 32'd6);
        chk("br_rf_pc", 32'((n_rf - s_rf) * 16 + (n_pc - s_pc)), 32'h01);
        do_instr(6'd0, 0, 0, 0);
        chk("br_latency", 32'(ir_gap), 32'd3);
        s_ir = n_ir;
        do_dead(3'd5, 6);
        after();
        chk("halt_no_ir_we", 32'(n_ir - s_ir), 32'd0);
        chk("halted", 32'(halted), 32'd1);
        iv_hi = 1'b0;
        do_reset();

        // ALU timeout on op 20
        s_exec = n_exec; s_pc = n_pc;
        do_instr(6'd20, 0, 1000, 0);
        do_dead(3'd6, 3);
        after();
        chk("to_exec_cycles", 32'(n_exec - s_exec), 32'd32);
        chk("to_no_pc_we", 32'(n_pc - s_pc), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        do_reset();

        // timeout boundary: alu_done on the expiry cycle still completes
        do_instr(6'd21, 0, T - 1, 0);
        for (int i = 0; i < 4; i++) do_instr(6'd1, $urandom_range(0, 1), 0, 0);
        idle();
        chk("ret_w2_sat", 32'(ret2), 32'd3);
        chk("ret_w16_five", 32'(ret16), 32'd5);

        // reset in the middle of a memory access
        cyc(1'b1, 6'd24, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, 0, 0, 0));
        cyc(1'b0, 6'd0, 1'b0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, 6'd0, 1'b0, 1'b0, mk(3'd3, 0, 0, 1, 0, 0, 0));
        do_reset();

        // randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            int r, d, k;
            logic [5:0] op;
            r = int'($urandom % 20);
            if (r == 0)      op = 6'd0;
            else if (r == 1) op = 6'($urandom_range(32, 63));
            else if (r < 6) begin
                case ($urandom % 4)
                    0: op = 6'd3;
                    1: op = 6'd4;
                    2: op = 6'd20;
                    default: op = 6'd21;
                endcase
            end else op = 6'($urandom_range(1, 31));
            d = ($urandom % 8 == 0) ? int'($urandom_range(T - 2, T + 4)) : int'($urandom_range(0, 6));
            k = int'($urandom_range(1, 5));
            do_instr(op, int'($urandom_range(0, 2)), d, k);
            if (op == 6'd0) begin
                do_dead(3'd5, int'($urandom_range(1, 3)));
                do_reset();
            end else if (op >= 6'd32 ||
                         ((op == 6'd3 || op == 6'd4 || op == 6'd20 || op == 6'd21) && d >= T)) begin
                do_dead(3'd6, int'($urandom_range(1, 3)));
                do_reset();
            end
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
